muldiv_seq: RTL and testbench



---
 rtl/muldiv_seq_pkg.sv | 70 +++++++
 rtl/muldiv_dp.sv | 70 +++++++
 rtl/muldiv_seq.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: ALU operation
// codes, FSM state encoding, iteration count and an operation decoder.
// Contains no logic of its own; imported by muldiv_seq and muldiv_dp.
package muldiv_seq_pkg;

    localparam int MXLEN   = 32;
    localparam int MD_ITER = 32;

    // Decoder ALU_* operation codes (5 bits). Only the M ops are handled by
    // the sequencer; the base codes are listed so the encodings stay together.
    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_AND    = 5'd2;
    localparam logic [4:0] ALU_OR     = 5'd3;
    localparam logic [4:0] ALU_XOR    = 5'd4;
    localparam logic [4:0] ALU_SLL    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_SLT    = 5'd8;
    localparam logic [4:0] ALU_SLTU   = 5'd9;
    localparam logic [4:0] ALU_MUL    = 5'd10;
    localparam logic [4:0] ALU_MULH   = 5'd11;
    localparam logic [4:0] ALU_MULHSU = 5'd12;
    localparam logic [4:0] ALU_MULHU  = 5'd13;
    localparam logic [4:0] ALU_DIV    = 5'd14;
    localparam logic [4:0] ALU_DIVU   = 5'd15;
    localparam logic [4:0] ALU_REM    = 5'd16;
    localparam logic [4:0] ALU_REMU   = 5'd17;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_PREP = 3'd1,
        MD_CALC = 3'd2,
        MD_FIX  = 3'd3,
        MD_DONE = 3'd4
    } md_state_t;

    // Per-operation attributes derived from the ALU code.
    typedef struct packed {
        logic is_m;      // one of the eight M ops
        logic is_mul;    // multiply family
        logic hi_half;   // return product bits [2*XLEN-1:XLEN]
        logic is_quot;   // DIV / DIVU
        logic is_rem;    // REM / REMU
        logic a_signed;  // rs1 interpreted as two's complement
        logic b_signed;  // rs2 interpreted as two's complement
    } md_op_t;

    function automatic md_op_t decode_op(input logic [4:0] op);
        md_op_t d;
        d = '0;
        case (op)
            ALU_MUL:    begin d.is_m = 1'b1; d.is_mul = 1'b1; end
            ALU_MULH:   begin d.is_m = 1'b1; d.is_mul = 1'b1; d.hi_half = 1'b1;
                              d.a_signed = 1'b1; d.b_signed = 1'b1; end
            ALU_MULHSU: begin d.is_m = 1'b1; d.is_mul = 1'b1; d.hi_half = 1'b1;
                              d.a_signed = 1'b1; end
            ALU_MULHU:  begin d.is_m = 1'b1; d.is_mul = 1'b1; d.hi_half = 1'b1; end
            ALU_DIV:    begin d.is_m = 1'b1; d.is_quot = 1'b1;
                              d.a_signed = 1'b1; d.b_signed = 1'b1; end
            ALU_DIVU:   begin d.is_m = 1'b1; d.is_quot = 1'b1; end
            ALU_REM:    begin d.is_m = 1'b1; d.is_rem = 1'b1;
                              d.a_signed = 1'b1; d.b_signed = 1'b1; end
            ALU_REMU:   begin d.is_m = 1'b1; d.is_rem = 1'b1; end
            default:    d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/muldiv_dp.sv
// Iterative shift-add multiply / restoring divide datapath, one bit per step.
// Latency: MD_ITER steps after load; last flags the final step.
// Backpressure: none; advances only when the sequencer asserts step.
// Ports: clk/rst; load with opa/opb/is_div starts an operation; step advances
// one iteration; acc is the product (mul) or partial remainder in the low
// XLEN+1 bits (div); shreg holds the quotient after a divide.
import muldiv_seq_pkg::*;

module muldiv_dp #(
    parameter int XLEN = MXLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   opa,
    input  logic [XLEN-1:0]   opb,
    output logic [2*XLEN-1:0] acc,
    output logic [XLEN-1:0]   shreg,
    output logic              last
);

    localparam logic [5:0] LAST_CNT = 6'(MD_ITER - 1);

    logic [XLEN-1:0] opnd;     // multiplicand or divisor, held for the whole op
    logic [5:0]      cnt;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   trial;
    logic [XLEN+1:0] diff;
    logic            fits;

    always_comb begin
        // Multiply: add the multiplicand into the upper half when the current
        // multiplier bit is set; the carry becomes the new top bit after shift.
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (shreg[0] ? {1'b0, opnd} : '0);
        // Divide: shift the next dividend bit into the partial remainder and
        // try subtracting the divisor; keep the difference only if non-negative.
        trial   = {acc[XLEN-1:0], shreg[XLEN-1]};
        diff    = {1'b0, trial} - {2'b00, opnd};
        fits    = ~diff[XLEN+1];
    end

    assign last = (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            shreg <= '0;
            opnd  <= '0;
            cnt   <= '0;
        end else if (load) begin
            acc   <= '0;
            cnt   <= '0;
            // Multiplier (mul) or dividend (div) goes into the shift register.
            shreg <= is_div ? opa : opb;
            opnd  <= is_div ? opb : opa;
        end else if (step) begin
            cnt <= cnt + 6'd1;
            if (is_div) begin
                acc   <= {{(XLEN-1){1'b0}}, (fits ? diff[XLEN:0] : trial)};
                shreg <= {shreg[XLEN-2:0], fits};
            end else begin
                acc   <= {mul_sum, acc[XLEN-1:1]};
                shreg <= shreg >> 1;
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: FSM, request/response handshake, sign fix.
// Latency: 35 cycles accept-to-response normally, 2 for special cases.
// Backpressure: result held in DONE until rsp_ready; req_ready only in IDLE.
// Ports: clk, rst (sync active-high); req_valid/req_ready with alu_ops, rs1,
// rs2; flush aborts; rsp_valid/rsp_ready with result; busy = not IDLE.
import muldiv_seq_pkg::*;

module muldiv_seq #(
    parameter int XLEN = MXLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      alu_ops,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t         state, next_state;
    logic [4:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic              neg_q;
    logic [XLEN-1:0]   result_q;

    md_op_t            dec;
    logic              div_op;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              neg_d;

    logic              accept;
    logic              dp_load, dp_step;
    logic              neg_we;
    logic              result_we;
    logic [XLEN-1:0]   result_d;

    logic [2*XLEN-1:0] dp_acc;
    logic [XLEN-1:0]   dp_shreg;
    logic              dp_last;
    logic [2*XLEN-1:0] prod_fix;

    assign dec    = decode_op(op_q);
    assign div_op = dec.is_quot | dec.is_rem;

    // Signs and magnitudes of the latched operands.
    always_comb begin
        neg_a = dec.a_signed & a_q[XLEN-1];
        neg_b = dec.b_signed & b_q[XLEN-1];
        abs_a = neg_a ? (~a_q + 1'b1) : a_q;
        abs_b = neg_b ? (~b_q + 1'b1) : b_q;
        // Remainder follows the dividend; products and quotients follow XOR.
        neg_d = dec.is_rem ? neg_a : (neg_a ^ neg_b);
        // Negate the full product so the high half is correct for MULH/MULHSU.
        prod_fix = neg_q ? (~dp_acc + 1'b1) : dp_acc;
    end

    muldiv_dp #(
        .XLEN (XLEN)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (dp_load),
        .step   (dp_step),
        .is_div (div_op),
        .opa    (abs_a),
        .opb    (abs_b),
        .acc    (dp_acc),
        .shreg  (dp_shreg),
        .last   (dp_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        dp_load    = 1'b0;
        dp_step    = 1'b0;
        neg_we     = 1'b0;
        result_we  = 1'b0;
        result_d   = '0;

        case (state)
            MD_IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = MD_PREP;
                end
            end
            MD_PREP: begin
                if (!dec.is_m) begin
                    result_we  = 1'b1;
                    result_d   = '0;
                    next_state = MD_DONE;
                end else if (div_op && (b_q == '0)) begin
                    result_we  = 1'b1;
                    result_d   = dec.is_quot ? '1 : a_q;
                    next_state = MD_DONE;
                end else if (div_op && dec.a_signed &&
                             (a_q == INT_MIN) && (b_q == '1)) begin
                    result_we  = 1'b1;
                    result_d   = dec.is_quot ? INT_MIN : '0;
                    next_state = MD_DONE;
                end else begin
                    dp_load    = 1'b1;
                    neg_we     = 1'b1;
                    next_state = MD_CALC;
                end
            end
            MD_CALC: begin
                dp_step = 1'b1;
                if (dp_last) begin
                    next_state = MD_FIX;
                end
            end
            MD_FIX: begin
                result_we = 1'b1;
                if (dec.is_mul) begin
                    result_d = dec.hi_half ? prod_fix[2*XLEN-1:XLEN]
                                           : prod_fix[XLEN-1:0];
                end else if (dec.is_quot) begin
                    result_d = neg_q ? (~dp_shreg + 1'b1) : dp_shreg;
                end else begin
                    result_d = neg_q ? (~dp_acc[XLEN-1:0] + 1'b1)
                                     : dp_acc[XLEN-1:0];
                end
                next_state = MD_DONE;
            end
            MD_DONE: begin
                if (rsp_ready) begin
                    next_state = MD_IDLE;
                end
            end
            default: next_state = MD_IDLE;
        endcase

        // Abort overrides everything, including a request in the same cycle.
        if (flush) begin
            next_state = MD_IDLE;
            accept     = 1'b0;
            dp_load    = 1'b0;
            dp_step    = 1'b0;
            neg_we     = 1'b0;
            result_we  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q <= alu_ops;
                a_q  <= rs1;
                b_q  <= rs2;
            end
            if (neg_we) begin
                neg_q <= neg_d;
            end
            if (result_we) begin
                result_q <= result_d;
            end
        end
    end

    assign req_ready = (state == MD_IDLE);
    assign rsp_valid = (state == MD_DONE);
    assign busy      = (state != MD_IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed test of muldiv_seq: products, quotients, special cases,
// backpressure, flush and reset. Prints one summary line at the end.
import muldiv_seq_pkg::*;

module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  alu_ops;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] result;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .alu_ops   (alu_ops),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure the edge at which rsp_valid is first seen
    // (counted from the accept edge), optionally stall the response, then
    // complete the handshake and confirm the block is ready the next cycle.
    task automatic run_op(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat,
                          input int hold);
        int lat;
        int unstable;
        @(negedge clk);
        check({tag, " req_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        alu_ops   = op;
        rs1       = a;
        rs2       = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        alu_ops   = ALU_DIV;
        rs1       = $urandom;
        rs2       = $urandom;
        check({tag, " busy after accept"}, {31'b0, busy}, 32'd1);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, result, exp);
        if (hold > 0) begin
            unstable = 0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (result !== exp || rsp_valid !== 1'b1) unstable++;
            end
            check({tag, " held result stable"}, unstable, 0);
            check({tag, " req_ready while held"}, {31'b0, req_ready}, 32'd0);
            check({tag, " busy while held"}, {31'b0, busy}, 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, " req_ready after handshake"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        req_valid = 1'b0;
        alu_ops   = '0;
        rs1       = '0;
        rs2       = '0;
        flush     = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", {31'b0, req_ready}, 32'd1);
        check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset result",    result, 32'd0);
        check("reset busy",      {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Multiply family
        run_op("MUL",    ALU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 35, 0);
        run_op("MULH",   ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 35, 0);
        run_op("MULHU",  ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35, 0);
        run_op("MULHSU", ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 35, 0);

        // Non-M op resolves to zero in PREP
        run_op("ADD",    ALU_ADD,    32'd3,        32'd4,        32'd0,         2, 0);

        // Division, with a stalled response followed by a back-to-back request
        run_op("DIV",    ALU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35, 0);
        run_op("REM",    ALU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35, 0);
        run_op("DIVU",   ALU_DIVU,   32'd100,      32'd7,        32'd14,       35, 10);
        run_op("REMU",   ALU_REMU,   32'd100,      32'd7,        32'd2,        35, 0);

        // Special cases
        run_op("DIV0",   ALU_DIV,    32'd5,        32'd0,        32'hFFFFFFFF,  2, 0);
        run_op("REMU0",  ALU_REMU,   32'd5,        32'd0,        32'd5,         2, 0);
        run_op("DIVOVF", ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000,  2, 0);
        run_op("REMOVF", ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,         2, 0);

        // Flush at accept+10 while in CALC
        @(negedge clk);
        req_valid = 1'b1;
        alu_ops   = ALU_DIVU;
        rs1       = 32'd100;
        rs2       = 32'd7;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("flush busy before", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush req_ready",  {31'b0, req_ready}, 32'd1);
        check("flush busy after", {31'b0, busy}, 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("flush rsp_valid never", seen, 0);

        // Flush and request together in IDLE: request is dropped
        @(negedge clk);
        req_valid = 1'b1;
        flush     = 1'b1;
        alu_ops   = ALU_MUL;
        rs1       = 32'd3;
        rs2       = 32'd5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        check("idle flush busy",      {31'b0, busy}, 32'd0);
        check("idle flush req_ready", {31'b0, req_ready}, 32'd1);

        // Reset mid-CALC after a completed op left a non-zero result
        run_op("MUL35",  ALU_MUL,    32'd3,        32'd5,        32'd15,       35, 0);
        @(negedge clk);
        req_valid = 1'b1;
        alu_ops   = ALU_MULHU;
        rs1       = 32'hFFFFFFFF;
        rs2       = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst mid req_ready", {31'b0, req_ready}, 32'd1);
        check("rst mid rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst mid result",    result, 32'd0);
        check("rst mid busy",      {31'b0, busy}, 32'd0);

        // Recovery after reset
        run_op("DIVU2",  ALU_DIVU,   32'd100,      32'd7,        32'd14,       35, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
